// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses a 1-cycle registered ROM, holds the word for a valid/ready consumer.
// First valid 2 cycles after reset, at best 3 cycles per instruction; VALID holds until ready or redirect.
module instr_fetch_unit #(
  parameter int          PC_WIDTH   = 32,
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [PC_WIDTH-1:0]   pc_o,
  output logic [PC_WIDTH-1:0]   pc_plus4_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  input  logic                  redirect_i,
  input  logic [PC_WIDTH-1:0]   redirect_pc_i,
  output logic [31:0]           fetch_count_o
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_VALID} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [PC_WIDTH-1:0]   r_pc_q;
  logic [PC_WIDTH-1:0]   w_pc_next;
  logic [PC_WIDTH-1:0]   r_pc_o;
  logic [DATA_WIDTH-1:0] r_instr;
  logic                  r_valid;
  logic [31:0]           r_count;
  logic                  w_handshake;
  logic                  w_capture;
  logic                  w_unused;

  always_comb begin
    w_next      = r_state;
    w_pc_next   = r_pc_q;
    w_handshake = (r_state == S_VALID) && instr_ready_i;
    w_capture   = 1'b0;
    case (r_state)
      S_FETCH: w_next = S_WAIT;
      S_WAIT: begin
        w_next    = S_VALID;
        w_capture = !redirect_i;
      end
      S_VALID: begin
        if (w_handshake) begin
          w_next    = S_FETCH;
          w_pc_next = r_pc_q + PC_WIDTH'(4);
        end
      end
      default: w_next = S_FETCH;
    endcase
    // Redirect overrides the sequential PC even when a handshake completes alongside it.
    if (redirect_i) begin
      w_next    = S_FETCH;
      w_pc_next = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc_q  <= RESET_PC;
      r_pc_o  <= RESET_PC;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_pc_q  <= w_pc_next;
      r_valid <= (w_next == S_VALID);
      if (w_capture) begin
        r_instr <= rom_data;
        r_pc_o  <= r_pc_q;
      end
      if (w_handshake) r_count <= r_count + 32'd1;
    end
  end

  // High PC bits alias in the ROM; the low bits are always zero.
  assign w_unused      = ^{redirect_pc_i[1:0], r_pc_q};
  assign rom_addr      = r_pc_q[ADDR_WIDTH+1:2];
  assign instr_o       = r_instr;
  assign pc_o          = r_pc_o;
  assign pc_plus4_o    = r_pc_o + PC_WIDTH'(4);
  assign instr_valid_o = r_valid;
  assign fetch_count_o = r_count;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction ROM (1-cycle registered read).
- Owns the program counter and drives the ROM word address.
- Captures the returned word into an instruction register and hands it to the multi-cycle control/decode FSM over a valid/ready handshake.
- Accepts branch/jump redirects from the control FSM; counts retired fetches.

Parameters:
- PC_WIDTH, 32, byte-address width of the PC.
- ADDR_WIDTH, 10, ROM word-address width; must satisfy ADDR_WIDTH <= PC_WIDTH-2.
- DATA_WIDTH, 32, instruction width; equals the ROM DATA_WIDTH.
- RESET_PC, 0, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; asynchronous, active-high.
- rom_addr  output  ADDR_WIDTH  word address to ROM; equals pc_q[ADDR_WIDTH+1:2], combinational from the PC register.
- rom_data  input  DATA_WIDTH  ROM read data; valid the cycle after the address is presented.
- instr_o  output  DATA_WIDTH  captured instruction.
- pc_o  output  PC_WIDTH  byte address of instr_o.
- pc_plus4_o  output  PC_WIDTH  pc_o + 4, modulo 2**PC_WIDTH.
- instr_valid_o  output  1  instr_o/pc_o hold a valid instruction.
- instr_ready_i  input  1  consumer accepts the instruction.
- redirect_i  input  1  load a new PC (branch/jump).
- redirect_pc_i  input  PC_WIDTH  redirect target; bits [1:0] ignored and forced to 0.
- fetch_count_o  output  32  number of completed handshakes; wraps at 2**32.

Behaviour:
- Reset (async, applied immediately):
  - pc_q = RESET_PC; state = FETCH.
  - instr_o = 0; instr_valid_o = 0; fetch_count_o = 0.
  - pc_o = RESET_PC; pc_plus4_o = RESET_PC+4.
- FSM states: FETCH, WAIT, VALID.
  - FETCH: rom_addr = pc_q (the ROM samples it at this edge). Next state: WAIT.
  - WAIT: rom_data carries mem[pc_q]. At the edge: instr_o <= rom_data; pc_o <= pc_q. Next state: VALID.
  - VALID: instr_valid_o = 1. instr_o and pc_o stay stable until the handshake. On instr_ready_i & instr_valid_o: pc_q <= pc_q+4, fetch_count_o++, next state FETCH. Otherwise stay in VALID.
- instr_valid_o is a registered output, high only in VALID.
- Latency and throughput:
  - First valid 2 cycles after leaving reset (FETCH→WAIT→VALID).
  - Minimum 3 cycles per instruction.
  - Consumer may hold ready high permanently.
- Redirect (any state, sampled at posedge):
  - pc_q <= {redirect_pc_i[PC_WIDTH-1:2], 2'b00}; next state FETCH.
  - instr_valid_o low in the next cycle.
  - In WAIT: rom_data is discarded and instr_o is not updated.
  - In VALID with the handshake in the same cycle: the handshake completes (fetch_count_o increments) and redirect wins for the PC (pc_q = target, not +4).
  - In VALID without the handshake: the held instruction is dropped and the count is unchanged.
- Arithmetic and width rules:
  - PC increment wraps modulo 2**PC_WIDTH.
  - PC bits above ADDR_WIDTH+1 are not sent to the ROM, so the address aliases; this is not an error.
- rom_addr changes only when pc_q changes, i.e. after a handshake or redirect, never during WAIT.
- Reset mid-operation (any state): identical to power-on reset. An in-flight ROM read is ignored.
- instr_ready_i is ignored outside VALID and has no effect on the count.

Test Plan:
- ROM words 0..2 = 0x20080005, 0x20090003, 0x01095020; instr_ready_i=1 constant after reset release:
  - instr_valid_o high in cycles 2, 5, 8.
  - instr_o/pc_o = 0x20080005/0x0, 0x20090003/0x4, 0x01095020/0x8.
  - fetch_count_o = 3 after cycle 8.
- Back-pressure: instr_ready_i=0 for 10 cycles while in VALID.
  - instr_o = 0x20080005, pc_o = 0, rom_addr = 0 held stable throughout.
  - Raising ready completes exactly one handshake; pc advances to 0x4.
- Redirect during WAIT to 0x00000013:
  - pc_q = 0x10 (low bits forced to 0); rom_addr = 4.
  - The stale word is never presented on instr_o.
  - Next valid is ROM word 4 with pc_o = 0x10.
- Redirect and handshake in the same VALID cycle, target 0x40:
  - fetch_count_o increments by 1.
  - Next instruction comes from pc 0x40, not pc_o+4.
- Wrap: RESET_PC = 0xFFFFFFFC:
  - First fetch at rom_addr = 0x3FF; pc_plus4_o = 0x0.
  - After the handshake, pc wraps to 0x0 and rom_addr = 0.
- Async reset asserted mid-WAIT, between clock edges:
  - Immediately instr_valid_o = 0, fetch_count_o = 0, rom_addr = RESET_PC[ADDR_WIDTH+1:2].
  - Fetch restarts from FETCH on release.
